pipe_bypass_regs: RTL
=====================

// Module: pipe_bypass_regs
// PURPOSE
// Holds the D/E/M/W pipeline registers of the 5-stage MIPS core and acts on the hazard unit's outputs.
// Consumes the stall request and five forward-select codes; freezes or bubbles stages and steers the bypass muxes.
// Feeds ir_d/ir_e/ir_m/ir_w back to the hazard unit and produces write-back address, data and enable.
// ALU, data memory and register file stay outside; their results arrive on ports.
// PARAMETERS
// W       32   datapath width (instruction, PC and data)
// RA_LINK 31   link register index written by jal
// PORTS
// clk        in   1  rising-edge clock
// reset_n    in   1  asynchronous, active-low reset
// ir_f       in   W  fetched instruction
// pc_f       in   W  PC of ir_f
// delay      in   1  stall request from hazard unit
// fwd_rsd    in   3  D-stage rs select; fwd_rtd/fwd_rse/fwd_rte same shape
// fwd_rtm    in   3  M-stage store-data select
// rf_rs_d    in   W  register file read data for rs of ir_d; rf_rt_d likewise
// alu_res_e  in   W  ALU result from E operands
// dm_rdata_m in   W  memory read data, already extended, for ir_m
// ir_d/ir_e/ir_m/ir_w  out  W  stage instructions to hazard unit and decoders
// pc_en      out  1  PC write enable to fetch = ~delay
// rs_fwd_d, rt_fwd_d   out  W  forwarded branch/jr operands
// rs_fwd_e, rt_fwd_e   out  W  forwarded ALU operands
// rt_fwd_m   out  W  forwarded store data
// wa_w       out  5  write-back register; wd_w out W data; we_w out 1 enable
// BEHAVIOUR
// - reset_n low, asynchronous: every register clears to 0. All ir_* read 0 (nop), all data/pc regs read 0, we_w=0.
// - Normal edge (delay=0): F->D (ir,pc), D->E, E->M, M->W. pc8_d = pc_d+8, carried as pc8_e/pc8_m/pc8_w. Wrap-around is mod 2^W.
// - E capture: rs_e <= rf_rs_d, except W-bypass: we_w & wa_w==rs(ir_d) & wa_w!=0 gives wd_w. rt_e is handled the same way.
// - M capture: alu_m<=alu_res_e, st_m<=rt_fwd_e, pc8_m<=pc8_e.
// - W capture: alu_w<=alu_m, mem_w<=dm_rdata_m, pc8_w<=pc8_m.
// - delay=1 edge: D holds (ir_d, pc_d unchanged). E loads bubble: ir_e=0, all E data=0. M and W advance normally.
// - delay on consecutive cycles: D stays frozen and E receives a bubble every cycle.
// - No flush: the branch delay slot always executes.
// - Forward codes, all combinational, zero latency:
//   - D: 0 = rf value with W-bypass above, 1 = wd_w, 2 = pc8_m, 3 = alu_m, 4 = pc8_e.
//   - E: 0 = E reg, 1 = wd_w, 2 = pc8_m, 3 = alu_m.
//   - M: 0 = st_m, 1 = wd_w.
//   - Any undefined code (D 5-7, E 4-7, M 2-7) selects code 0.
// - Write-back decode from ir_w:
//   - R-type (op 0, func != 001000): wa=rd.
//   - ori/lui/lb/lbu/lh/lhu/lw: wa=rt.
//   - jal: wa=RA_LINK.
//   - all other instructions: wa=0.
//   - we_w = (wa!=0).
//   - wd_w = mem_w for loads; pc8_w for jal/jalr (op 0, func 001001); otherwise alu_w.
//   - nop (ir=0) gives wa=0, we=0.
// - Reset asserted mid-stall: clears immediately. First edge after release loads ir_f into D.
// TESTING
// - Reset mid-run with ir_e=0x02328021 pending: reset_n low (no clock) -> all ir_*=0, we_w=0, wd_w=0.
// - Stall: ir_d=A, ir_e=B, delay=1 for 1 edge -> ir_d=A, ir_e=0, ir_m=B, pc_en=0 during stall. Next edge ir_e=A.
// - Fwd: alu_m=0x1234, fwd_rse=3 -> rs_fwd_e=0x1234. pc8_e=0x3008, fwd_rsd=4 -> rs_fwd_d=0x3008. fwd_rte=6 -> E reg.
// - jal in W with pc_w=0x3000 -> wa_w=31, wd_w=0x3008, we_w=1. jr in W -> we_w=0.
// - W-bypass: W writes $5=0xDEAD, rf_rs_d stale 0, ir_d rs=5 -> after edge rs_e=0xDEAD. Same with wa_w=0 -> rs_e=0.
// - Store: sw in M, lw $8 in W with mem_w=0x55, fwd_rtm=1 -> rt_fwd_m=0x55. fwd_rtm=0 -> st_m.

Source files
------------

// File: rtl/pipe_bypass_regs_if.sv
// Hazard/datapath bundle for the D/E/M/W pipeline register block.
// The master side drives fetch, hazard and datapath results; the slave side is the register block.
interface pipe_bypass_regs_if #(
  parameter int W = 32
);
  logic [W-1:0] ir_f;
  logic [W-1:0] pc_f;
  logic         delay;
  logic [2:0]   fwd_rsd;
  logic [2:0]   fwd_rtd;
  logic [2:0]   fwd_rse;
  logic [2:0]   fwd_rte;
  logic [2:0]   fwd_rtm;
  logic [W-1:0] rf_rs_d;
  logic [W-1:0] rf_rt_d;
  logic [W-1:0] alu_res_e;
  logic [W-1:0] dm_rdata_m;

  logic [W-1:0] ir_d;
  logic [W-1:0] ir_e;
  logic [W-1:0] ir_m;
  logic [W-1:0] ir_w;
  logic         pc_en;
  logic [W-1:0] rs_fwd_d;
  logic [W-1:0] rt_fwd_d;
  logic [W-1:0] rs_fwd_e;
  logic [W-1:0] rt_fwd_e;
  logic [W-1:0] rt_fwd_m;
  logic [4:0]   wa_w;
  logic [W-1:0] wd_w;
  logic         we_w;

  modport master (
    output ir_f, pc_f, delay, fwd_rsd, fwd_rtd, fwd_rse, fwd_rte, fwd_rtm,
           rf_rs_d, rf_rt_d, alu_res_e, dm_rdata_m,
    input  ir_d, ir_e, ir_m, ir_w, pc_en, rs_fwd_d, rt_fwd_d, rs_fwd_e,
           rt_fwd_e, rt_fwd_m, wa_w, wd_w, we_w
  );

  modport slave (
    input  ir_f, pc_f, delay, fwd_rsd, fwd_rtd, fwd_rse, fwd_rte, fwd_rtm,
           rf_rs_d, rf_rt_d, alu_res_e, dm_rdata_m,
    output ir_d, ir_e, ir_m, ir_w, pc_en, rs_fwd_d, rt_fwd_d, rs_fwd_e,
           rt_fwd_e, rt_fwd_m, wa_w, wd_w, we_w
  );
endinterface

// File: rtl/pipe_bypass_regs.sv
// D/E/M/W pipeline registers of the 5-stage MIPS core with stall/bubble control,
// bypass muxes steered by the hazard unit, and write-back address/data decode.
module pipe_bypass_regs #(
  parameter int         W       = 32,
  parameter logic [4:0] RA_LINK = 5'd31
) (
  input  logic             clk,
  input  logic             reset_n,
  pipe_bypass_regs_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  logic [W-1:0] ir_d, pc_d;
  logic [W-1:0] ir_e, pc8_e, rs_e, rt_e;
  logic [W-1:0] ir_m, pc8_m, alu_m, st_m;
  logic [W-1:0] ir_w, pc8_w, alu_w, mem_w;

  logic [4:0]   wa;
  logic [W-1:0] wd;
  logic         we;
  logic         is_load_w;
  logic [5:0]   op_w, fn_w;
  logic [W-1:0] rs_byp_d, rt_byp_d;
  logic [W-1:0] rs_fwd_d, rt_fwd_d, rs_fwd_e, rt_fwd_e, rt_fwd_m;

  // D stage freezes while the hazard unit requests a stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_d <= '0;
      pc_d <= '0;
    end else if (!bus.delay) begin
      ir_d <= bus.ir_f;
      pc_d <= bus.pc_f;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_e  <= '0;
      pc8_e <= '0;
      rs_e  <= '0;
      rt_e  <= '0;
    end else if (bus.delay) begin
      ir_e  <= '0;
      pc8_e <= '0;
      rs_e  <= '0;
      rt_e  <= '0;
    end else begin
      ir_e  <= ir_d;
      pc8_e <= pc_d + W'(8);
      rs_e  <= rs_byp_d;
      rt_e  <= rt_byp_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_m  <= '0;
      pc8_m <= '0;
      alu_m <= '0;
      st_m  <= '0;
      ir_w  <= '0;
      pc8_w <= '0;
      alu_w <= '0;
      mem_w <= '0;
    end else begin
      ir_m  <= ir_e;
      pc8_m <= pc8_e;
      alu_m <= bus.alu_res_e;
      st_m  <= rt_fwd_e;
      ir_w  <= ir_m;
      pc8_w <= pc8_m;
      alu_w <= alu_m;
      mem_w <= bus.dm_rdata_m;
    end
  end

  // Write-back destination and data decoded from the instruction in W.
  always_comb begin
    op_w      = ir_w[31:26];
    fn_w      = ir_w[5:0];
    wa        = 5'd0;
    is_load_w = 1'b0;
    case (op_w)
      OP_RTYPE: wa = (fn_w == FN_JR) ? 5'd0 : ir_w[15:11];
      OP_ORI, OP_LUI: wa = ir_w[20:16];
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        wa        = ir_w[20:16];
        is_load_w = 1'b1;
      end
      OP_JAL: wa = RA_LINK;
      default: wa = 5'd0;
    endcase
    we = (wa != 5'd0);
    if (is_load_w)
      wd = mem_w;
    else if (op_w == OP_JAL || (op_w == OP_RTYPE && fn_w == FN_JALR))
      wd = pc8_w;
    else
      wd = alu_w;
  end

  // Register-file read through the write port, so same-cycle W writes are not lost.
  always_comb begin
    rs_byp_d = (we && wa == ir_d[25:21]) ? wd : bus.rf_rs_d;
    rt_byp_d = (we && wa == ir_d[20:16]) ? wd : bus.rf_rt_d;
  end

  always_comb begin
    case (bus.fwd_rsd)
      3'd1:    rs_fwd_d = wd;
      3'd2:    rs_fwd_d = pc8_m;
      3'd3:    rs_fwd_d = alu_m;
      3'd4:    rs_fwd_d = pc8_e;
      default: rs_fwd_d = rs_byp_d;
    endcase
    case (bus.fwd_rtd)
      3'd1:    rt_fwd_d = wd;
      3'd2:    rt_fwd_d = pc8_m;
      3'd3:    rt_fwd_d = alu_m;
      3'd4:    rt_fwd_d = pc8_e;
      default: rt_fwd_d = rt_byp_d;
    endcase
    case (bus.fwd_rse)
      3'd1:    rs_fwd_e = wd;
      3'd2:    rs_fwd_e = pc8_m;
      3'd3:    rs_fwd_e = alu_m;
      default: rs_fwd_e = rs_e;
    endcase
    case (bus.fwd_rte)
      3'd1:    rt_fwd_e = wd;
      3'd2:    rt_fwd_e = pc8_m;
      3'd3:    rt_fwd_e = alu_m;
      default: rt_fwd_e = rt_e;
    endcase
    rt_fwd_m = (bus.fwd_rtm == 3'd1) ? wd : st_m;
  end

  assign bus.ir_d     = ir_d;
  assign bus.ir_e     = ir_e;
  assign bus.ir_m     = ir_m;
  assign bus.ir_w     = ir_w;
  assign bus.pc_en    = ~bus.delay;
  assign bus.rs_fwd_d = rs_fwd_d;
  assign bus.rt_fwd_d = rt_fwd_d;
  assign bus.rs_fwd_e = rs_fwd_e;
  assign bus.rt_fwd_e = rt_fwd_e;
  assign bus.rt_fwd_m = rt_fwd_m;
  assign bus.wa_w     = wa;
  assign bus.wd_w     = wd;
  assign bus.we_w     = we;

endmodule
